// File: rtl/psum_gather_if.sv
// rtl/psum_gather_if.sv - lane-beat input and assembled-bundle output bus of psum_gather
//   clr            : synchronous flush (master -> slave)
//   in_valid       : beat present (master -> slave)
//   in_last        : final beat of a bundle (master -> slave)
//   in_data        : LANES x 4-bit two's-complement lane values (master -> slave)
//   data_out_valid : one-cycle bundle-complete pulse (slave -> master)
//   data_out       : GROUPS x CH x 4-bit encoded bundle (slave -> master)
//   err            : sticky framing error (slave -> master)
interface psum_gather_if #(
    parameter int LANES  = 16,
    parameter int CH     = 64,
    parameter int GROUPS = 2
) ();
    logic                          clr;
    logic                          in_valid;
    logic                          in_last;
    logic [LANES-1:0][3:0]         in_data;
    logic                          data_out_valid;
    logic [GROUPS-1:0][CH-1:0][3:0] data_out;
    logic                          err;

    modport master (
        output clr, in_valid, in_last, in_data,
        input  data_out_valid, data_out, err
    );

    modport slave (
        input  clr, in_valid, in_last, in_data,
        output data_out_valid, data_out, err
    );
endinterface

// File: rtl/psum_gather.sv
// rtl/psum_gather.sv - gathers LANES-wide 4-bit beats into an encoded GROUPS x CH partial-sum bundle
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : psum_gather_if.slave (clr, in_valid, in_last, in_data -> data_out_valid, data_out, err)
module psum_gather #(
    parameter int LANES  = 16,
    parameter int CH     = 64,
    parameter int GROUPS = 2,
    parameter int ENCODE = 1
) (
    input  logic         clk,
    input  logic         rstn,
    psum_gather_if.slave bus
);
    localparam int N     = GROUPS * CH;
    localparam int BEATS = N / LANES;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [BCW-1:0] LAST_BC = BCW'(BEATS - 1);

    logic [BCW-1:0]        bc_q, bc_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;
    logic [N-1:0][3:0]     asm_q, asm_d;
    logic [N-1:0][3:0]     out_q, out_d;
    logic [N-1:0][3:0]     merged;
    logic [LANES-1:0][3:0] beat_enc;
    logic [IW-1:0]         idx;

    // Adder decode expects the magnitude bits inverted, sign kept.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            if (ENCODE != 0) begin
                beat_enc[l] = {bus.in_data[l][3], ~bus.in_data[l][2:0]};
            end else begin
                beat_enc[l] = bus.in_data[l];
            end
        end
    end

    // Assembly buffer with the current beat dropped into its group-major slot;
    // used both for mid-bundle capture and for the final-beat output load.
    always_comb begin
        merged = asm_q;
        idx    = '0;
        for (int l = 0; l < LANES; l++) begin
            idx         = IW'(int'(bc_q) * LANES + l);
            merged[idx] = beat_enc[l];
        end
    end

    always_comb begin
        bc_d    = bc_q;
        err_d   = err_q;
        valid_d = 1'b0;
        asm_d   = asm_q;
        out_d   = out_q;
        if (bus.clr) begin
            bc_d  = '0;
            err_d = 1'b0;
        end else if (bus.in_valid) begin
            if (bus.in_last != (bc_q == LAST_BC)) begin
                // Framing violation: discard the partial bundle, restart at beat 0.
                bc_d  = '0;
                err_d = 1'b1;
            end else if (bus.in_last) begin
                out_d   = merged;
                valid_d = 1'b1;
                bc_d    = '0;
            end else begin
                asm_d = merged;
                bc_d  = bc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bc_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            asm_q   <= '0;
            out_q   <= '0;
        end else begin
            bc_q    <= bc_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
        end
    end

    assign bus.data_out_valid = valid_q;
    assign bus.data_out       = out_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_psum_gather.sv
// tb/tb_psum_gather.sv - randomized self-checking bench for psum_gather (encoded and raw instances)
module tb_psum_gather;
    localparam int LANES  = 16;
    localparam int CH     = 64;
    localparam int GROUPS = 2;
    localparam int N      = GROUPS * CH;
    localparam int BEATS  = N / LANES;

    typedef logic [3:0] bundle_t [N];
    typedef logic [LANES-1:0][3:0] beat_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    psum_gather_if #(.LANES(LANES), .CH(CH), .GROUPS(GROUPS)) enc_if ();
    psum_gather_if #(.LANES(LANES), .CH(CH), .GROUPS(GROUPS)) raw_if ();

    psum_gather #(.LANES(LANES), .CH(CH), .GROUPS(GROUPS), .ENCODE(1)) u_enc (
        .clk  (clk),
        .rstn (rstn),
        .bus  (enc_if.slave)
    );

    psum_gather #(.LANES(LANES), .CH(CH), .GROUPS(GROUPS), .ENCODE(0)) u_raw (
        .clk  (clk),
        .rstn (rstn),
        .bus  (raw_if.slave)
    );

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int stable_err = 0;
    logic [GROUPS-1:0][CH-1:0][3:0] last_seen;
    bundle_t last_good;

    // Pulse counter and hold-stability watcher, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            last_seen = enc_if.data_out;
        end else if (enc_if.data_out_valid) begin
            pulses++;
            last_seen = enc_if.data_out;
        end else if (enc_if.data_out !== last_seen) begin
            stable_err++;
        end
    end

    // Encoding as arithmetic: sign kept, low three bits become 7 - low.
    function automatic logic [3:0] enc(input logic [3:0] v);
        return (v & 4'd8) | (4'd7 - (v & 4'd7));
    endfunction

    // Number of output elements differing from the reference bundle.
    function automatic int bundle_mism(input bundle_t v, input bit raw);
        int n = 0;
        logic [3:0] exp_v, got;
        for (int g = 0; g < GROUPS; g++) begin
            for (int c = 0; c < CH; c++) begin
                exp_v = raw ? v[g*CH + c] : enc(v[g*CH + c]);
                got   = raw ? raw_if.data_out[g][c] : enc_if.data_out[g][c];
                if (got !== exp_v) n++;
            end
        end
        return n;
    endfunction

    function automatic beat_t beat_of(input bundle_t v, input int b);
        beat_t d;
        for (int l = 0; l < LANES; l++) d[l] = v[b*LANES + l];
        return d;
    endfunction

    function automatic beat_t rand_beat();
        beat_t d;
        for (int l = 0; l < LANES; l++) d[l] = 4'($urandom_range(0, 15));
        return d;
    endfunction

    task automatic rand_bundle(output bundle_t v);
        for (int i = 0; i < N; i++) v[i] = 4'($urandom_range(0, 15));
    endtask

    // Present one cycle of inputs to both instances; returns 1ns after the edge.
    task automatic drive(input bit v, input bit last, input bit c, input beat_t d);
        enc_if.in_valid = v; enc_if.in_last = last; enc_if.clr = c; enc_if.in_data = d;
        raw_if.in_valid = v; raw_if.in_last = last; raw_if.clr = c; raw_if.in_data = d;
        @(posedge clk);
        #1;
        enc_if.in_valid = 1'b0; enc_if.in_last = 1'b0; enc_if.clr = 1'b0;
        raw_if.in_valid = 1'b0; raw_if.in_last = 1'b0; raw_if.clr = 1'b0;
    endtask

    task automatic send_bundle(input bundle_t v, input int max_gap);
        for (int b = 0; b < BEATS; b++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) drive(1'b0, 1'b0, 1'b0, rand_beat());
            end
            drive(1'b1, b == BEATS - 1, 1'b0, beat_of(v, b));
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (enc_if.data_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", enc_if.data_out_valid);
        end
        checks++;
        if (enc_if.err !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b exp=0", enc_if.err);
        end
        checks++;
        if (enc_if.data_out !== '0) begin
            failures++; $display("FAIL reset_data got_nonzero exp=0");
        end
        rstn = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_complete();
        bundle_t v;
        int p0, n;
        for (int i = 0; i < N; i++) v[i] = (i < CH) ? 4'd3 : 4'hF;
        p0 = pulses;
        send_bundle(v, 0);
        checks++;
        if (enc_if.data_out_valid !== 1'b1) begin
            failures++; $display("FAIL complete_valid got=%b exp=1", enc_if.data_out_valid);
        end
        n = 0;
        for (int c = 0; c < CH; c++) begin
            if (enc_if.data_out[0][c] !== 4'b0100) n++;
            if (enc_if.data_out[1][c] !== 4'b1000) n++;
        end
        checks++;
        if (n != 0) begin
            failures++; $display("FAIL complete_data mismatches=%0d exp=0", n);
        end
        checks++;
        if (enc_if.err !== 1'b0) begin
            failures++; $display("FAIL complete_err got=%b exp=0", enc_if.err);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (enc_if.data_out_valid !== 1'b0) begin
            failures++; $display("FAIL complete_pulse_width got=%b exp=0", enc_if.data_out_valid);
        end
        checks++;
        if (pulses - p0 != 1) begin
            failures++; $display("FAIL complete_pulses got=%0d exp=1", pulses - p0);
        end
    endtask

    task automatic test_index();
        bundle_t v;
        int n;
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < LANES; l++)
                v[b*LANES + l] = 4'((b*16 + l) % 8);
        send_bundle(v, 0);
        n = bundle_mism(v, 1'b0);
        checks++;
        if (n != 0) begin
            failures++; $display("FAIL index_encoded mismatches=%0d exp=0", n);
        end
        n = bundle_mism(v, 1'b1);
        checks++;
        if (n != 0) begin
            failures++; $display("FAIL index_raw mismatches=%0d exp=0", n);
        end
        last_good = v;
        drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        bundle_t v;
        int p0, n;
        p0 = pulses;
        stable_err = 0;
        for (int k = 0; k < 4; k++) begin
            rand_bundle(v);
            send_bundle(v, (k < 2) ? 3 : 0);
            n = bundle_mism(v, 1'b0);
            checks++;
            if (n != 0 || enc_if.data_out_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b_bundle%0d mismatches=%0d valid=%b exp=0/1", k, n, enc_if.data_out_valid);
            end
            if (k == 0) repeat ($urandom_range(1, 4)) drive(1'b0, 1'b0, 1'b0, rand_beat());
        end
        last_good = v;
        drive(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (pulses - p0 != 4) begin
            failures++; $display("FAIL b2b_pulses got=%0d exp=4", pulses - p0);
        end
        checks++;
        if (stable_err != 0) begin
            failures++; $display("FAIL b2b_stable changes=%0d exp=0", stable_err);
        end
    endtask

    task automatic test_framing();
        bundle_t v;
        int n;
        // Early in_last on beat 3.
        for (int b = 0; b < 4; b++) drive(1'b1, b == 3, 1'b0, rand_beat());
        n = bundle_mism(last_good, 1'b0);
        checks++;
        if (enc_if.data_out_valid !== 1'b0 || enc_if.err !== 1'b1 || n != 0) begin
            failures++;
            $display("FAIL early_last valid=%b err=%b mism=%0d exp=0/1/0", enc_if.data_out_valid, enc_if.err, n);
        end
        rand_bundle(v);
        send_bundle(v, 1);
        n = bundle_mism(v, 1'b0);
        checks++;
        if (enc_if.data_out_valid !== 1'b1 || n != 0 || enc_if.err !== 1'b1) begin
            failures++;
            $display("FAIL recover1 valid=%b mism=%0d err=%b exp=1/0/1", enc_if.data_out_valid, n, enc_if.err);
        end
        last_good = v;
        drive(1'b0, 1'b0, 1'b1, '0);
        checks++;
        if (enc_if.err !== 1'b0) begin
            failures++; $display("FAIL clr_err got=%b exp=0", enc_if.err);
        end
        // Missing in_last on beat 7.
        for (int b = 0; b < BEATS; b++) begin
            drive(1'b1, 1'b0, 1'b0, rand_beat());
            if (b == BEATS - 2) begin
                checks++;
                if (enc_if.err !== 1'b0) begin
                    failures++; $display("FAIL missing_last_early_err got=%b exp=0", enc_if.err);
                end
            end
        end
        n = bundle_mism(last_good, 1'b0);
        checks++;
        if (enc_if.data_out_valid !== 1'b0 || enc_if.err !== 1'b1 || n != 0) begin
            failures++;
            $display("FAIL missing_last valid=%b err=%b mism=%0d exp=0/1/0", enc_if.data_out_valid, enc_if.err, n);
        end
        rand_bundle(v);
        send_bundle(v, 0);
        n = bundle_mism(v, 1'b0);
        checks++;
        if (enc_if.data_out_valid !== 1'b1 || n != 0) begin
            failures++; $display("FAIL recover2 valid=%b mism=%0d exp=1/0", enc_if.data_out_valid, n);
        end
        last_good = v;
        drive(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_clr();
        bundle_t v;
        int p0, n;
        drive(1'b1, 1'b1, 1'b0, rand_beat());
        checks++;
        if (enc_if.err !== 1'b1) begin
            failures++; $display("FAIL clr_pre_err got=%b exp=1", enc_if.err);
        end
        for (int b = 0; b < 5; b++) drive(1'b1, 1'b0, 1'b0, rand_beat());
        p0 = pulses;
        drive(1'b1, 1'b0, 1'b1, rand_beat());
        n = bundle_mism(last_good, 1'b0);
        checks++;
        if (enc_if.err !== 1'b0 || enc_if.data_out_valid !== 1'b0 || n != 0) begin
            failures++;
            $display("FAIL clr_cycle err=%b valid=%b mism=%0d exp=0/0/0", enc_if.err, enc_if.data_out_valid, n);
        end
        rand_bundle(v);
        send_bundle(v, 0);
        n = bundle_mism(v, 1'b0);
        checks++;
        if (n != 0 || enc_if.err !== 1'b0) begin
            failures++; $display("FAIL clr_post mism=%0d err=%b exp=0/0", n, enc_if.err);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (pulses - p0 != 1) begin
            failures++; $display("FAIL clr_pulses got=%0d exp=1", pulses - p0);
        end
    endtask

    task automatic test_reset_mid();
        bundle_t v;
        int n;
        drive(1'b1, 1'b1, 1'b0, rand_beat());
        for (int b = 0; b < 6; b++) drive(1'b1, 1'b0, 1'b0, rand_beat());
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (enc_if.data_out_valid !== 1'b0 || enc_if.err !== 1'b0 || enc_if.data_out !== '0 || raw_if.data_out !== '0) begin
            failures++;
            $display("FAIL reset_mid valid=%b err=%b data_zero=%b exp=0/0/1", enc_if.data_out_valid, enc_if.err, enc_if.data_out === '0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rand_bundle(v);
        send_bundle(v, 2);
        n = bundle_mism(v, 1'b0) + bundle_mism(v, 1'b1);
        checks++;
        if (enc_if.data_out_valid !== 1'b1 || n != 0) begin
            failures++; $display("FAIL reset_recover valid=%b mism=%0d exp=1/0", enc_if.data_out_valid, n);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (stable_err != 0) begin
            failures++; $display("FAIL final_stable changes=%0d exp=0", stable_err);
        end
    endtask

    initial begin
        enc_if.clr = 1'b0; enc_if.in_valid = 1'b0; enc_if.in_last = 1'b0; enc_if.in_data = '0;
        raw_if.clr = 1'b0; raw_if.in_valid = 1'b0; raw_if.in_last = 1'b0; raw_if.in_data = '0;
        test_reset();
        test_complete();
        test_index();
        test_back_to_back();
        test_framing();
        test_clr();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_gather.md
# psum_gather

Source side of the partial-sum reduction interface in Layer3. The block collects 4-bit signed macro results arriving over a narrow lane bus, `LANES` values per beat. It assembles them into the full `data_out[1:0][63:0]` bundle consumed by the partial-sum adder, and applies the adder's bit encoding so that the adder's decode step recovers the original values. When a bundle completes, the block presents it with a single-cycle valid pulse. The downstream interface has no ready signal, so this block never stalls.

## Interface
Parameters:
- `LANES`, default 16: 4-bit values per input beat; must divide `GROUPS*CH`.
- `CH`, default 64: channels per group.
- `GROUPS`, default 2: groups per bundle.
- `ENCODE`, default 1: 1 applies the encoding `{v[3], ~v[2:0]}`; 0 passes values raw.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `clr`  in  1: synchronous flush; drops the partial bundle and clears `err`.
- `in_valid`  in  1: beat present; accepted every cycle it is high.
- `in_last`  in  1: marks the final beat of a bundle.
- `in_data[LANES-1:0]`  in  4 signed each: lane values for the current beat.
- `data_out_valid`  out  1: one-cycle pulse when a bundle is complete.
- `data_out[GROUPS-1:0][CH-1:0]`  out  4 signed each: encoded bundle.
- `err`  out  1: sticky framing error.

## Operation
- `BEATS = GROUPS*CH/LANES`, which is 8 at defaults. The beat counter `bc` runs from 0 to `BEATS-1`.
- Beat order is group-major:
  - Beat b, lane l maps to flat index `b*LANES+l`.
  - The group is `idx/CH` and the channel is `idx%CH`.
  - At defaults, beats 0–3 fill group 0 and beats 4–7 fill group 1.
- Encoding is applied per lane on capture. Examples: +3 = 0011 encodes to 0100; -1 = 1111 encodes to 1000; -8 = 1000 encodes to 1111; +7 = 0111 encodes to 0000.
- Assembly buffer:
  - A beat with `bc < BEATS-1` and `in_last=0` writes its lanes into the assembly buffer and increments `bc`.
  - `data_out` is not touched during assembly.
- Final beat (`bc == BEATS-1` and `in_last=1`):
  - `data_out` is loaded with the assembly buffer merged with the current beat.
  - `data_out_valid` is set, and `bc` wraps to 0.
- Framing error:
  - Triggered by `in_last=1` with `bc != BEATS-1`, or by `in_last=0` with `bc == BEATS-1`.
  - The bundle is discarded: no valid pulse, and `data_out` is unchanged.
  - `bc` returns to 0 and `err` is set.
  - The next beat is treated as beat 0.
- `data_out` holds its last completed bundle until the next bundle completes. Partial updates are never visible on `data_out`.
- `clr=1`:
  - `bc` goes to 0 and `err` goes to 0.
  - Any beat presented in the same cycle is dropped, and no valid pulse is produced.
  - `data_out` is unchanged.
- `in_valid=0` leaves all state unchanged; idle gaps of any length between beats are legal.

## Timing
- Reset values: `data_out_valid=0`, `data_out` all 0, `err=0`, `bc=0`, assembly buffer all 0.
- Reset asserted mid-bundle discards the partial bundle.
- Latency: the final beat is accepted at edge N, and `data_out_valid` and `data_out` are visible after edge N. The pulse is exactly one cycle unless another bundle completes at edge N+1.
- Back-to-back bundles:
  - Beat 0 of the next bundle may arrive in the cycle directly after the final beat.
  - Sustained throughput is one bundle per `BEATS` cycles.
  - With `LANES = GROUPS*CH` (`BEATS=1`), valid may stay high continuously.
- `err` rises the cycle after the offending beat. It stays high until `clr` is asserted or reset.
- Priority when events coincide: reset, then `clr`, then framing check, then normal capture.

## Test plan
- Complete bundle: 8 beats with group-0 lanes = +3 and group-1 lanes = -1. Required: `data_out[0][*]=4'b0100` and `data_out[1][*]=4'b1000`. `data_out_valid` is high for one cycle, one cycle after beat 7, and `err=0`.
- Index mapping: beat b, lane l carries `(b*16+l)%8`. Required: for every index `i = b*16+l`, `data_out[i/64][i%64]` equals the encoded value of `(b*16+l)%8`. Repeat with `ENCODE=0` and check raw values.
- Gaps and back-to-back: two bundles with random `in_valid` gaps, then two bundles with no gaps. Required: exactly 4 valid pulses, each bundle's data correct, and `data_out` stable between pulses.
- Framing errors:
  - `in_last` on beat 3: no pulse, `err=1`, `data_out` retains the previous bundle; the following 8 clean beats produce a valid bundle.
  - Missing `in_last` on beat 7: same required behaviour.
- `clr` mid-bundle:
  - 5 beats, then `clr` together with `in_valid`, then 8 clean beats. Required: exactly one pulse, containing only the post-`clr` data, and `err` cleared.
- Reset mid-bundle: `rstn` low after 6 beats. Required: all outputs 0 immediately. A fresh 8-beat bundle after release emits correctly.
